hall_call_encoder: RTL
======================

Name: hall_call_encoder

Overview:
- Upstream front-end of the two-car elevator system.
- Samples raw hall-call buttons and synchronises/debounces them.
- Latches each call as pending and serialises new calls into the system's single request port (req_valid/req_new), one floor per cycle, round-robin.
- Clears a pending call once either car reports that floor.

Parameters:
NFLOORS, 16, number of floors/buttons; must satisfy NFLOORS <= 2**FLOOR_W
FLOOR_W, 4, floor index width; matches the system's req_new/floor_l1/floor_l2 width
DEBOUNCE_CYC, 4, consecutive synchronised-high cycles required to accept a press (1..255)
REISSUE_CYC, 255, cycles an issued call may wait before re-issue (only with HALL_CALL_REISSUE_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
btn  input  NFLOORS  raw asynchronous hall buttons, bit i = floor i, high = pressed
floor_l1  input  FLOOR_W  current floor of car 1, from the system
floor_l2  input  FLOOR_W  current floor of car 2, from the system
req_valid  output  1  one-cycle strobe: req_new carries a new call
req_new  output  FLOOR_W  floor index of the issued call
pending  output  NFLOORS  bit i high while floor i is NEW or ISSUED (for hall lamps)

Behaviour:
- Reset (rst=0, async): all sync flops, debounce counters, call states, RR pointer and timers cleared; req_valid=0, req_new=0, pending=0. Reset mid-operation discards all calls; nothing is re-issued after release.
- Input path per floor: 2-FF synchroniser, then debounce counter. Counter increments while sync output is 1 and saturates at DEBOUNCE_CYC; 0 clears it. db_i=1 when counter==DEBOUNCE_CYC. A press is a 0->1 transition of db_i.
- Per-floor call FSM, states IDLE, NEW, ISSUED:
  - IDLE -> NEW on press, unless floor_l1==i or floor_l2==i that cycle (call already satisfied; discarded).
  - NEW -> ISSUED when selected by the arbiter.
  - NEW or ISSUED -> IDLE when floor_l1==i or floor_l2==i. Served has priority over selection and re-press.
  - A press while NEW or ISSUED is ignored (no duplicate request).
- Arbiter:
  - Each cycle, selects the first NEW floor scanning i = ptr, ptr+1, ..., wrapping at NFLOORS-1 -> 0. Excludes floors being served that cycle.
  - If one is found: registered output next cycle req_valid=1, req_new=i; ptr <= i+1 (wraps to 0 after NFLOORS-1).
  - If none is found: req_valid=0; req_new holds its last value.
- Throughput and latency:
  - At most one request per cycle; no backpressure (the system accepts every strobe).
  - Uncontended latency: req_valid asserts on edge DEBOUNCE_CYC+3, counting the first edge sampling btn=1 as edge 0. That is 2 sync edges + DEBOUNCE_CYC count edges, and the edge that counter reaches DEBOUNCE_CYC sets NEW, then 1 output register.
- pending: registered from FSM state; updates on the same edge as the state change.
- A button held continuously produces exactly one call. A new call requires release (db_i=0) and re-press.

Optional Feature:
HALL_CALL_REISSUE_EN
- Defined: per-floor timer of width $clog2(REISSUE_CYC+1), cleared on entry to ISSUED and incremented while ISSUED. On reaching REISSUE_CYC the call returns to NEW and is re-arbitrated normally. Served in the same cycle wins (-> IDLE).
- Undefined: no timers; ISSUED leaves only when served.

Decomposition:
- Package elevator_pkg holds:
  - FLOOR_W and NFLOORS defaults
  - call_state_t enum {CALL_IDLE, CALL_NEW, CALL_ISSUED}
  - floor_t typedef (logic [FLOOR_W-1:0])
- One sub-module, call_debounce (synchroniser + saturating counter + rising-edge pulse), instantiated NFLOORS times.
- FSMs, arbiter and output register stay in hall_call_encoder.

Test Plan:
- Reset release, btn[5] held high from edge 0, cars at 0 and 9 -> req_valid=1, req_new=5 on edge 7 for exactly one cycle; pending[5]=1.
- btn[5] glitch high for 3 cycles then low (DEBOUNCE_CYC=4) -> no req_valid; pending stays 0.
- btn[2], btn[7] and btn[12] rise on the same edge, ptr=0 -> req_new 2, 7, 12 on three consecutive cycles; ptr ends at 13. Then btn[1] and btn[14] together -> 14 first, then 1 (wrap).
- Call 3 ISSUED, floor_l2 becomes 3 -> pending[3] clears next edge. Re-press 3 while car still at 3 -> discarded, no req_valid. Re-press while ISSUED before service -> no second request.
- Calls 4 and 6 ISSUED, rst pulsed low mid-stream -> all outputs 0 immediately; after release no request until a fresh debounced press.
- With HALL_CALL_REISSUE_EN, REISSUE_CYC=10, call 8 unserved -> req_new=8 reissued 11 cycles after the first strobe. Without the macro -> single strobe only.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types for the two-car elevator system: floor index, hall-call state
// and default sizing.
package elevator_pkg;

  localparam int NFLOORS_DEFAULT = 16;
  localparam int FLOOR_W_DEFAULT = 4;

  typedef logic [FLOOR_W_DEFAULT-1:0] floor_t;

  typedef enum logic [1:0] {
    CALL_IDLE   = 2'd0,
    CALL_NEW    = 2'd1,
    CALL_ISSUED = 2'd2
  } call_state_t;

endpackage

// File: rtl/call_debounce.sv
// One hall button: 2-FF synchroniser, saturating debounce counter and a
// one-cycle press pulse on the rising edge of the debounced level.
module call_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYC);

  logic [1:0] sync_q, sync_d;
  logic [7:0] cnt_q, cnt_d;
  logic       db;
  logic       db_q, db_d;

  always_comb begin
    sync_d = {sync_q[0], btn_raw};
    cnt_d  = '0;
    if (sync_q[1]) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
    end
    db    = (cnt_q == CNT_MAX);
    db_d  = db;
    press = db & ~db_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

endmodule

// File: rtl/hall_call_encoder.sv
// Hall-call front end: debounced presses become pending calls that are issued
// one per cycle, round-robin. Optional re-issue of stale calls: HALL_CALL_REISSUE_EN.
module hall_call_encoder
  import elevator_pkg::*;
#(
  parameter int NFLOORS      = NFLOORS_DEFAULT,
  parameter int FLOOR_W      = FLOOR_W_DEFAULT,
  parameter int DEBOUNCE_CYC = 4,
  parameter int REISSUE_CYC  = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0] floor_l1,
  input  logic [FLOOR_W-1:0] floor_l2,
  output logic               req_valid,
  output logic [FLOOR_W-1:0] req_new,
  output logic [NFLOORS-1:0] pending
);

  if (NFLOORS > (1 << FLOOR_W) || DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > 255 ||
      REISSUE_CYC < 1) begin : g_param_check
    $error("hall_call_encoder: illegal parameter combination");
  end

  logic [NFLOORS-1:0] press;
  logic [NFLOORS-1:0] served;
  logic [NFLOORS-1:0] cand;
  logic [NFLOORS-1:0] expire;

  call_state_t state_q [NFLOORS];
  call_state_t state_d [NFLOORS];

  logic               found;
  logic [FLOOR_W-1:0] sel;
  logic [FLOOR_W-1:0] ptr_q, ptr_d;
  logic               req_valid_q, req_valid_d;
  logic [FLOOR_W-1:0] req_new_q, req_new_d;

  for (genvar g = 0; g < NFLOORS; g++) begin : g_btn
    call_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn[g]),
      .press   (press[g])
    );
  end

  // A floor where either car currently stands is satisfied this cycle.
  always_comb begin
    served = '0;
    cand   = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      served[i] = (floor_l1 == FLOOR_W'(i)) || (floor_l2 == FLOOR_W'(i));
      cand[i]   = (state_q[i] == CALL_NEW) && !served[i];
    end
  end

  always_comb begin
    logic [FLOOR_W:0] idx;
    idx   = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NFLOORS; k++) begin
      idx = {1'b0, ptr_q} + (FLOOR_W+1)'(k);
      if (idx >= (FLOOR_W+1)'(NFLOORS)) begin
        idx = idx - (FLOOR_W+1)'(NFLOORS);
      end
      if (!found && cand[idx[FLOOR_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[FLOOR_W-1:0];
      end
    end
  end

`ifdef HALL_CALL_REISSUE_EN
  localparam int TMR_W = $clog2(REISSUE_CYC + 1);

  logic [TMR_W-1:0] timer_q [NFLOORS];
  logic [TMR_W-1:0] timer_d [NFLOORS];

  // Timer reads 0 on the first ISSUED cycle, so expiry is one count early.
  always_comb begin
    expire = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      timer_d[i] = (state_q[i] == CALL_ISSUED) ? timer_q[i] + 1'b1 : '0;
      expire[i]  = (state_q[i] == CALL_ISSUED) &&
                   (timer_q[i] == TMR_W'(REISSUE_CYC - 1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NFLOORS; i++) timer_q[i] <= '0;
    end else begin
      for (int i = 0; i < NFLOORS; i++) timer_q[i] <= timer_d[i];
    end
  end
`else
  assign expire = '0;
`endif

  // Service beats selection, re-press and expiry.
  always_comb begin
    for (int i = 0; i < NFLOORS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        CALL_IDLE:   if (press[i] && !served[i]) state_d[i] = CALL_NEW;
        CALL_NEW: begin
          if (served[i])                             state_d[i] = CALL_IDLE;
          else if (found && sel == FLOOR_W'(i))      state_d[i] = CALL_ISSUED;
        end
        CALL_ISSUED: begin
          if (served[i])      state_d[i] = CALL_IDLE;
          else if (expire[i]) state_d[i] = CALL_NEW;
        end
        default:     state_d[i] = CALL_IDLE;
      endcase
    end
  end

  always_comb begin
    req_valid_d = found;
    req_new_d   = found ? sel : req_new_q;
    ptr_d       = ptr_q;
    if (found) begin
      ptr_d = (sel == FLOOR_W'(NFLOORS - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NFLOORS; i++) state_q[i] <= CALL_IDLE;
      ptr_q       <= '0;
      req_valid_q <= 1'b0;
      req_new_q   <= '0;
    end else begin
      for (int i = 0; i < NFLOORS; i++) state_q[i] <= state_d[i];
      ptr_q       <= ptr_d;
      req_valid_q <= req_valid_d;
      req_new_q   <= req_new_d;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      pending[i] = (state_q[i] != CALL_IDLE);
    end
  end

  assign req_valid = req_valid_q;
  assign req_new   = req_new_q;

endmodule
